// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative signed mult/div on one shared 33-bit adder driving HI/LO.
// Define MULDIV_DIV_EN to build the divider; otherwise op=1 completes at once as a div_zero trap.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic             hilo_write,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
  state_t state, state_n;
  logic sa, sb, dz, launch, trap;
  logic [WIDTH-1:0] mag, abs_a, abs_b;
  logic [2*WIDTH-1:0] acc, acc_n, prod;
  logic [WIDTH:0] add_a, add_b, sum;
  logic [4:0] cnt;
`ifdef MULDIV_DIV_EN
  logic op_r;
  logic [WIDTH-1:0] quo, rem;
`endif
  assign abs_a = a[WIDTH-1] ? -a : a;
  assign abs_b = b[WIDTH-1] ? -b : b;
  assign launch = start && (state == IDLE || state == DONE);
`ifdef MULDIV_DIV_EN
  assign trap = launch && op && (b == '0);
`else
  assign trap = launch && op;
`endif
  always_comb begin
    state_n = launch ? (trap ? DONE : RUN)
            : state == RUN  ? (cnt == 5'd31 ? FIX : RUN)
            : state == FIX  ? DONE
            : state == DONE ? IDLE : state;
  end
  // Shared adder: mult adds |a| to the upper half; div subtracts |b| from the shifted remainder.
  always_comb begin
`ifdef MULDIV_DIV_EN
    add_a = op_r ? {1'b0, acc[2*WIDTH-2:WIDTH-1]} : {1'b0, acc[2*WIDTH-1:WIDTH]};
    add_b = op_r ? ~{1'b0, mag} : {1'b0, mag};
    sum   = add_a + add_b + {{WIDTH{1'b0}}, op_r};
    acc_n = op_r ? (sum[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0} : {sum[WIDTH-1:0], acc[WIDTH-2:0], 1'b1})
                 : (acc[0] ? {sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]});
`else
    add_a = {1'b0, acc[2*WIDTH-1:WIDTH]};
    add_b = {1'b0, mag};
    sum   = add_a + add_b;
    acc_n = acc[0] ? {sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};
`endif
  end
  assign prod = (sa ^ sb) ? -acc : acc;
`ifdef MULDIV_DIV_EN
  assign quo = (sa ^ sb) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem = sa ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
`endif
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      sa    <= 1'b0;
      sb    <= 1'b0;
      dz    <= 1'b0;
      mag   <= '0;
      acc   <= '0;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      state <= state_n;
      if (launch) begin
        sa  <= a[WIDTH-1];
        sb  <= b[WIDTH-1];
        dz  <= trap;
        cnt <= '0;
`ifdef MULDIV_DIV_EN
        mag <= op ? abs_b : abs_a;
        acc <= {{WIDTH{1'b0}}, op ? abs_a : abs_b};
`else
        mag <= abs_a;
        acc <= {{WIDTH{1'b0}}, abs_b};
`endif
      end else if (state == RUN) begin
        acc <= acc_n;
        cnt <= cnt + 5'd1;
      end
      if (state == FIX) begin
`ifdef MULDIV_DIV_EN
        hi <= op_r ? rem : prod[2*WIDTH-1:WIDTH];
        lo <= op_r ? quo : prod[WIDTH-1:0];
`else
        hi <= prod[2*WIDTH-1:WIDTH];
        lo <= prod[WIDTH-1:0];
`endif
      end
    end
  end
`ifdef MULDIV_DIV_EN
  always_ff @(posedge clock) begin
    if (reset) op_r <= 1'b0;
    else if (launch) op_r <= op;
  end
`endif
  assign busy       = state == RUN || state == FIX;
  assign done       = state == DONE;
  assign div_zero   = done && dz;
  assign hilo_write = done && !dz;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: randomized + directed checks against an arithmetic reference model.
module tb_muldiv_sequencer;
`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif
  logic clock = 1'b0;
  logic reset, start, op;
  logic [31:0] a, b, hi, lo;
  logic busy, done, div_zero, hilo_write;
  logic [31:0] m_hi = '0, m_lo = '0;
  logic [31:0] corner [5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
  int n_cmp = 0, n_bad = 0;

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .div_zero(div_zero), .hilo_write(hilo_write),
    .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_op(input logic o, input logic [31:0] x, input logic [31:0] y, input bit poke);
    longint sx, sy, p, q, r;
    bit trap;
    int lat = 0, nbusy = 0;
    logic [31:0] e_hi, e_lo;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    trap = o && (!DIV_EN || y == 32'h0);
    e_hi = m_hi;
    e_lo = m_lo;
    if (!trap && !o) begin
      p = sx * sy;
      e_hi = p[63:32];
      e_lo = p[31:0];
    end else if (!trap) begin
      q = sx / sy;
      r = sx % sy;
      e_hi = r[31:0];
      e_lo = q[31:0];
    end
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clock);
      if (c == 1) begin
        start = 1'b0;
        op = 1'($urandom);
        a = $urandom;
        b = $urandom;
      end
      if (poke && c == 10) start = 1'b1;
      if (poke && c == 11) start = 1'b0;
      if (done) begin
        lat = c;
        break;
      end
      if (busy) nbusy++;
    end
    start = 1'b0;
    check("latency", 64'(lat), trap ? 64'd1 : 64'd34);
    check("busy_cycles", 64'(nbusy), trap ? 64'd0 : 64'd33);
    check("div_zero", 64'(div_zero), 64'(trap));
    check("hilo_write", 64'(hilo_write), 64'(!trap));
    check("busy_at_done", 64'(busy), 64'd0);
    check("hi", 64'(hi), 64'(e_hi));
    check("lo", 64'(lo), 64'(e_lo));
    m_hi = e_hi;
    m_lo = e_lo;
  endtask

  task automatic idle(input int n);
    start = 1'b0;
    repeat (n) @(negedge clock);
    check("idle_done", 64'(done), 64'd0);
    check("idle_hi", 64'(hi), 64'(m_hi));
    check("idle_lo", 64'(lo), 64'(m_lo));
  endtask

  function automatic logic [31:0] pick();
    return ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
  endfunction

  initial begin
    bit got_done;
    reset = 1'b1;
    start = 1'b0;
    op = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    check("rst_outs", {busy, done, div_zero, hilo_write}, 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);

    run_op(1'b0, 32'd7, -32'sd3, 1'b0);
    check("tp1_hi", 64'(hi), 64'hFFFF_FFFF);
    check("tp1_lo", 64'(lo), 64'hFFFF_FFEB);
    idle(2);
    run_op(1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0);
    check("tp2_hi", 64'(hi), 64'h4000_0000);
    run_op(1'b1, -32'sd7, 32'd2, 1'b0);
    idle(1);
    run_op(1'b1, 32'd100, 32'd0, 1'b0);
    idle(1);
    run_op(1'b1, 32'd100, 32'd3, 1'b0);
    idle(1);
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    idle(1);

    got_done = 1'b0;
    start = 1'b1;
    op = 1'b0;
    a = 32'd12345;
    b = 32'd678;
    for (int c = 1; c <= 25; c++) begin
      @(negedge clock);
      if (c == 1) start = 1'b0;
      if (c == 10) start = 1'b1;
      if (c == 11) start = 1'b0;
      if (done) got_done = 1'b1;
      if (c == 21) begin
        check("abort_outs", {busy, done, div_zero, hilo_write}, 64'd0);
        check("abort_hilo", {hi, lo}, 64'd0);
        reset = 1'b0;
      end
      if (c == 20) reset = 1'b1;
    end
    check("abort_no_done", 64'(got_done), 64'd0);
    m_hi = '0;
    m_lo = '0;
    run_op(1'b0, 32'd12345, 32'd678, 1'b0);
    idle(1);

    for (int i = 0; i < 40; i++) begin
      int gap;
      gap = $urandom_range(0, 2);
      if (gap != 0) idle(gap);
      run_op(1'($urandom), pick(), pick(), $urandom_range(0, 3) == 0);
    end
    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
